// File: rtl/rtrt_pkg.sv
// Shared types and constants for the OCM stream reader.
package rtrt_pkg;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    FINISH
  } state_t;
endpackage

// File: rtl/pix_fifo.sv
// First-word-fall-through FIFO feeding the pixel stream. The head word is
// forced to zero while empty so the output is clean after reset.
module pix_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   pop,
  output logic [DATA_W-1:0]      rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: nothing is read until it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = (count != '0) ? mem[rptr] : '0;
endmodule

// File: rtl/ocm_stream_reader.sv
// Streams a burst of words from OCM port B into a ready/valid pixel stream,
// keeping issued-but-unpopped reads within the FIFO depth.
module ocm_stream_reader
  import rtrt_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 16
) (
  input  logic              MAIN_CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [ADDR_W-1:0] LENGTH,
  output logic [ADDR_W-1:0] OCM_ADDR_B,
  output logic              OCM_WE_B,
  output logic [DATA_W-1:0] OCM_DATAIN_B,
  input  logic [DATA_W-1:0] OCM_DATAOUT_B,
  output logic [DATA_W-1:0] PIX_DATA,
  output logic              PIX_VALID,
  input  logic              PIX_READY,
  output logic              BUSY,
  output logic              DONE
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_q, remain;
  logic              issue, inflight, pop;
  logic [CW-1:0]     fifo_count, outstanding;

  assign outstanding = fifo_count + CW'(inflight);
  assign pop         = PIX_VALID && PIX_READY;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:
        if (START) state_nxt = (LENGTH == '0) ? FINISH : FETCH;
      FETCH:
        if (outstanding < CW'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (remain == ADDR_W'(1)) state_nxt = DRAIN;
        end
      // Every read is issued by now; the burst ends when the last held word
      // leaves and nothing is still coming back from OCM.
      DRAIN:
        if (pop && fifo_count == CW'(1) && !inflight) state_nxt = FINISH;
      FINISH:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge MAIN_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      addr     <= '0;
      addr_q   <= '0;
      remain   <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (state == IDLE && START) begin
        addr   <= BASE_ADDR;
        remain <= LENGTH;
      end
      if (issue) begin
        addr   <= addr + 1'b1;
        remain <= remain - 1'b1;
        addr_q <= addr;
      end
    end
  end

  // The address goes out combinationally so the word returns one cycle later.
  assign OCM_ADDR_B   = issue ? addr : addr_q;
  assign OCM_WE_B     = 1'b0;
  assign OCM_DATAIN_B = '0;
  assign PIX_VALID    = (fifo_count != '0);
  assign BUSY         = (state != IDLE);
  assign DONE         = (state == FINISH);

  pix_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (MAIN_CLK),
    .rst_n (RESET_N),
    .push  (inflight),
    .wdata (OCM_DATAOUT_B),
    .pop   (pop),
    .rdata (PIX_DATA),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_ocm_stream_reader.sv
// Directed and randomized bursts against a queue-based model of the expected
// word stream, with a behavioural synchronous OCM behind port B.
module tb_ocm_stream_reader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] length = '0;
  logic [15:0] ocm_dout, ocm_addr, ocm_din, pix_data;
  logic        ocm_we, pix_valid, busy, done;
  logic [15:0] mem [0:65535];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ocm_dout <= mem[ocm_addr];

  ocm_stream_reader #(.FIFO_DEPTH(4), .DATA_W(16)) dut (
    .MAIN_CLK      (clk),
    .RESET_N       (rst_n),
    .START         (start),
    .BASE_ADDR     (base_addr),
    .LENGTH        (length),
    .OCM_ADDR_B    (ocm_addr),
    .OCM_WE_B      (ocm_we),
    .OCM_DATAIN_B  (ocm_din),
    .OCM_DATAOUT_B (ocm_dout),
    .PIX_DATA      (pix_data),
    .PIX_VALID     (pix_valid),
    .PIX_READY     (ready),
    .BUSY          (busy),
    .DONE          (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0/3: ready held high; 1: low for 10 cycles then random; 2: random.
  task automatic set_ready(input int mode, input int t);
    case (mode)
      1:       ready = (t < 10) ? 1'b0 : 1'($urandom_range(0, 1));
      2:       ready = 1'($urandom_range(0, 1));
      default: ready = 1'b1;
    endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"},  {16'h0, ocm_addr}, 32'h0);
    chk({tag, "_valid"}, {31'h0, pix_valid}, 32'h0);
    chk({tag, "_data"},  {16'h0, pix_data}, 32'h0);
    chk({tag, "_busy"},  {31'h0, busy}, 32'h0);
    chk({tag, "_done"},  {31'h0, done}, 32'h0);
  endtask

  // Called at a negedge in the middle of a burst.
  task automatic do_abort();
    start = 1'b0;
    ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_hold_done", {31'h0, done}, 32'h0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_done", {31'h0, done}, 32'h0);
      chk("post_abort_busy", {31'h0, busy}, 32'h0);
    end
  endtask

  task automatic run_burst(input logic [15:0] base, input int len, input int mode,
                           input int abort_after);
    logic [15:0] exp_q[$];
    int t = 0, first_v = -1, done_cnt = 0, done_t = -1, last_pop = -1;
    int busy_cnt = 0, popped = 0;
    bit fin = 0;
    for (int i = 0; i < len; i++) exp_q.push_back(mem[16'(base + 16'(i))]);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; length = 16'(len); ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 16'($urandom); length = 16'($urandom);
    set_ready(mode, 0);
    while (!fin && t < 400) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (pix_valid && first_v < 0) first_v = t;
      if (mode == 1 && t == 9) chk("stall_addr", {16'h0, ocm_addr}, {16'h0, 16'(base + 16'd3)});
      if (done) begin done_cnt++; done_t = t; end
      if (pix_valid) begin
        if (exp_q.size() == 0) chk("extra_word", 32'd1, 32'd0);
        else if (ready) begin
          chk("word", {16'h0, pix_data}, {16'h0, exp_q.pop_front()});
          popped++;
          last_pop = t;
        end else chk("hold", {16'h0, pix_data}, {16'h0, exp_q[0]});
      end
      if (abort_after > 0 && popped == abort_after) begin
        do_abort();
        return;
      end
      if (done_t >= 0 && t == done_t + 1) begin
        chk("done_low", {31'h0, done}, 32'h0);
        chk("busy_low", {31'h0, busy}, 32'h0);
        fin = 1;
      end else begin
        @(posedge clk); #1;
        t++;
        set_ready(mode, t);
        if (mode == 3) begin
          start = (t == 3);
          base_addr = 16'(base + 16'h100);
          length = 16'd5;
        end
      end
    end
    start = 1'b0;
    if (!fin) chk("timeout", 32'd0, 32'd1);
    chk("done_cnt", done_cnt, 32'd1);
    chk("word_cnt", popped, len);
    chk("busy_cycles", busy_cnt, done_t + 1);
    chk("we_zero", {31'h0, ocm_we}, 32'h0);
    chk("din_zero", {16'h0, ocm_din}, 32'h0);
    if (len == 0) begin
      chk("empty_valid", first_v, -1);
      chk("empty_done_t", done_t, 0);
    end else begin
      chk("first_valid_t", first_v, 2);
      chk("done_after_last", done_t, last_pop + 1);
      chk("addr_hold", {16'h0, ocm_addr}, {16'h0, 16'(base + 16'(len - 1))});
      if (mode == 0 || mode == 3) chk("last_pop_t", last_pop, len + 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) mem[16 + i] = 16'(16'h100 + i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    run_burst(16'h0010, 8, 0, 0);
    run_burst(16'hFFFE, 4, 0, 0);
    run_burst(16'h4000, 20, 1, 0);
    run_burst(16'h1234, 0, 0, 0);
    run_burst(16'h0010, 8, 2, 3);
    run_burst(16'h0010, 8, 0, 0);
    run_burst(16'h0200, 10, 3, 0);
    for (int k = 0; k < 6; k++)
      run_burst(16'($urandom), $urandom_range(1, 12), 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ocm_stream_reader.md
OCM_STREAM_READER -- requirements
Module: ocm_stream_reader

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, output buffer depth in words; power of two, minimum 2.
REQ-002 Parameter DATA_W, default 16, word width matching the OCM data ports.
REQ-003 MAIN_CLK  input  1  single clock; all state on rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 START  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 BASE_ADDR  input  16  first OCM word address; captured on accepted START.
REQ-007 LENGTH  input  16  word count; captured on accepted START; 0 = empty burst.
REQ-008 OCM_ADDR_B  output  16  read address to OCM port B.
REQ-009 OCM_WE_B  output  1  constant 0; block never writes.
REQ-010 OCM_DATAIN_B  output  16  constant 0.
REQ-011 OCM_DATAOUT_B  input  16  OCM read data, valid exactly 1 cycle after address.
REQ-012 PIX_DATA  output  16  stream word, head of FIFO.
REQ-013 PIX_VALID  output  1  FIFO non-empty.
REQ-014 PIX_READY  input  1  consumer accepts; transfer when PIX_VALID && PIX_READY.
REQ-015 BUSY  output  1  high from accepted START until DONE cycle inclusive.
REQ-016 DONE  output  1  one-cycle pulse when last word of burst is transferred out.

Function
REQ-017 FSM states IDLE, FETCH, DRAIN, FINISH; IDLE -> FETCH on START with LENGTH!=0; IDLE -> FINISH on START with LENGTH==0.
REQ-018 FETCH: issue one read per cycle while issued-but-unpopped count (FIFO count + in-flight) < FIFO_DEPTH; never overflow FIFO.
REQ-019 Issued read: OCM_ADDR_B = current address; in-flight flag set; next cycle OCM_DATAOUT_B pushed into FIFO.
REQ-020 Address increments by 1 per issued read, modulo 2^16 (0xFFFF -> 0x0000, no error).
REQ-021 FETCH -> DRAIN after the LENGTH-th read is issued; DRAIN -> FINISH on cycle the final word is popped.
REQ-022 FINISH lasts one cycle: DONE=1; then IDLE.
REQ-023 START ignored in FETCH, DRAIN, FINISH; BASE_ADDR/LENGTH changes while BUSY have no effect.
REQ-024 Simultaneous push and pop: count unchanged, both take effect.
REQ-025 PIX_DATA stable while PIX_VALID && !PIX_READY.
REQ-026 Peak throughput: 1 word/cycle with PIX_READY held high; first PIX_VALID 2 cycles after START acceptance.
REQ-027 Empty burst: DONE pulses the cycle after START; no OCM read issued, PIX_VALID stays 0.
REQ-028 OCM_ADDR_B holds last issued value when not issuing.

Reset
REQ-029 RESET_N low: state IDLE, FIFO empty, in-flight cleared, OCM_ADDR_B=0, PIX_VALID=0, PIX_DATA=0, BUSY=0, DONE=0.
REQ-030 Reset mid-burst aborts immediately; pending OCM data discarded; no DONE pulse.

Structure
REQ-031 Package rtrt_pkg holds the FSM state enum and ADDR_W=16 constant.
REQ-032 FIFO is sub-module pix_fifo (synchronous, FIFO_DEPTH x DATA_W, count output, first-word-fall-through).

Verification
REQ-033 BASE=0x0010, LENGTH=8, mem[0x10+i]=i+0x100, READY=1 -> words 0x0100..0x0107 in order, consecutive cycles, DONE once.
REQ-034 BASE=0xFFFE, LENGTH=4 -> reads 0xFFFE,0xFFFF,0x0000,0x0001 in order.
REQ-035 LENGTH=20, READY low 10 cycles then toggling -> no loss, no duplicate, issued reads stall at 4 outstanding.
REQ-036 LENGTH=0 -> DONE the next cycle, BUSY 1 cycle, no PIX_VALID.
REQ-037 RESET_N pulsed after 3 of 8 words popped -> all outputs at reset values, no DONE; new START runs cleanly.
REQ-038 START re-asserted while BUSY with different BASE -> ignored; original burst completes unchanged.
